// File: rtl/fp_pack_pkg.sv
// Shared field widths, class bit layout and lane classifier for the
// floating-point result pack stage.
package fp_pack_pkg;

   // Lane field widths: lane0 and lane1 of the packed mode, and the double lane
   localparam int L0_FRAC_W = 23;
   localparam int L0_EXP_W  = 8;
   localparam int L1_FRAC_W = 29;
   localparam int L1_EXP_W  = 8;
   localparam int DP_FRAC_W = 52;
   localparam int DP_EXP_W  = 11;

   // Class bit positions inside one 4-bit lane class nibble
   localparam int CLS_ZERO = 0;
   localparam int CLS_SUB  = 1;
   localparam int CLS_INF  = 2;
   localparam int CLS_NAN  = 3;

   localparam int WORD_W    = 70;
   localparam int CLASS_W   = 8;
   localparam int PAYLOAD_W = 1 + CLASS_W + WORD_W;

   // One buffered word: mode, per-lane class and packed data travel together
   typedef struct packed {
      logic               mode;
      logic [CLASS_W-1:0] cls;
      logic [WORD_W-1:0]  data;
   } word_t;

   // Classify one lane; expo/frac must be zero-extended above the lane width
   function automatic logic [3:0] classify(input logic [DP_EXP_W-1:0]  expo,
                                           input logic [DP_FRAC_W-1:0] frac,
                                           input int                   ewidth);
      logic [DP_EXP_W-1:0] ones;
      logic                exp_zero;
      logic                exp_ones;
      logic                frac_zero;
      ones      = DP_EXP_W'((1 << ewidth) - 1);
      exp_zero  = (expo == '0);
      exp_ones  = (expo == ones);
      frac_zero = (frac == '0);
      classify           = '0;
      classify[CLS_ZERO] = exp_zero & frac_zero;
      classify[CLS_SUB]  = exp_zero & ~frac_zero;
      classify[CLS_INF]  = exp_ones & frac_zero;
      classify[CLS_NAN]  = exp_ones & ~frac_zero;
   endfunction

endpackage

// File: rtl/fp_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main register drives the
// downstream side; the skid register catches one word while main is stalled.
// up_ready is a pure register output, so there is no path from dn_ready.
module fp_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   logic         main_valid_reg;
   logic [W-1:0] main_data_reg;
   logic         skid_valid_reg;
   logic [W-1:0] skid_data_reg;
   logic         up_xfer;
   logic         load_main;

   assign up_ready  = ~skid_valid_reg;
   assign dn_valid  = main_valid_reg;
   assign dn_data   = main_data_reg;
   assign up_xfer   = up_valid & ~skid_valid_reg;
   // Main can take a new word when it is empty or leaving this cycle
   assign load_main = ~main_valid_reg | dn_ready;

   // Main/skid update; skid always has priority into main to keep word order
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_reg <= 1'b0;
         main_data_reg  <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else begin
         if (load_main) begin
            main_valid_reg <= skid_valid_reg | up_xfer;
            if (skid_valid_reg) begin
               main_data_reg <= skid_data_reg;
            end else if (up_xfer) begin
               main_data_reg <= up_data;
            end
         end
         if (skid_valid_reg && load_main) begin
            skid_valid_reg <= 1'b0;
         end else if (up_xfer && !load_main) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= up_data;
         end
      end
   end

endmodule

// File: rtl/fp_result_pack.sv
// Output register stage of the dual-mode FP adder: packs sign/exponent/
// fraction into the final word, classifies each lane at capture, buffers
// through a skid buffer and keeps sticky class flags and a transfer count.
module fp_result_pack
   import fp_pack_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic              i_mode,
   input  logic [1:0]        i_sign,
   input  logic [51:0]       i_frac,
   input  logic [15:0]       i_expo,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              o_mode,
   output logic [69:0]       o_data,
   output logic [7:0]        o_class,
   input  logic              i_flag_clr,
   output logic [7:0]        o_flags,
   output logic [CNT_W-1:0]  o_count
);

   word_t            in_word;
   word_t            out_word;
   logic             out_xfer;
   logic [7:0]       flags_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Pack the incoming fields and classify each active lane
   always_comb begin
      in_word      = '0;
      in_word.mode = i_mode;
      if (i_mode) begin
         in_word.data     = {6'b0, i_sign[1], i_expo[DP_EXP_W-1:0], i_frac};
         in_word.cls[7:4] = classify(i_expo[DP_EXP_W-1:0], i_frac, DP_EXP_W);
      end else begin
         in_word.data     = {i_sign[1], i_expo[15:8], i_frac[51:23],
                             i_sign[0], i_expo[7:0],  i_frac[22:0]};
         in_word.cls[3:0] = classify({3'b0, i_expo[7:0]},
                                     {29'b0, i_frac[L0_FRAC_W-1:0]}, L0_EXP_W);
         in_word.cls[7:4] = classify({3'b0, i_expo[15:8]},
                                     {23'b0, i_frac[51:L0_FRAC_W]}, L1_EXP_W);
      end
   end

   fp_skid_buf #(
      .W (PAYLOAD_W)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (i_valid),
      .up_ready (i_ready),
      .up_data  (in_word),
      .dn_valid (o_valid),
      .dn_ready (o_ready),
      .dn_data  (out_word)
   );

   assign o_mode   = out_word.mode;
   assign o_class  = out_word.cls;
   assign o_data   = out_word.data;
   assign out_xfer = o_valid & o_ready;

   // Counter: clear first, then a same-cycle transfer adds one, saturating
   always_comb begin
      count_next = i_flag_clr ? '0 : count_reg;
      if (out_xfer && (count_next != {CNT_W{1'b1}})) begin
         count_next = count_next + 1'b1;
      end
   end

   // Sticky flags and transfer counter; a transfer survives a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_reg <= '0;
         count_reg <= '0;
      end else begin
         flags_reg <= (i_flag_clr ? 8'h00 : flags_reg) | (out_xfer ? out_word.cls : 8'h00);
         count_reg <= count_next;
      end
   end

   assign o_flags = flags_reg;
   assign o_count = count_reg;

endmodule

// File: tb/tb_fp_result_pack.sv
// Scoreboard bench for fp_result_pack: the stimulus pushes expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_fp_result_pack;

   typedef struct packed {
      logic        mode;
      logic [7:0]  cls;
      logic [69:0] data;
   } exp_t;

   typedef struct packed {
      logic        mode;
      logic [1:0]  sign;
      logic [15:0] expo;
      logic [51:0] frac;
      logic [69:0] data;
      logic [7:0]  cls;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        i_ready;
   logic        i_mode;
   logic [1:0]  i_sign;
   logic [51:0] i_frac;
   logic [15:0] i_expo;
   logic        o_valid;
   logic        o_ready;
   logic        o_mode;
   logic [69:0] o_data;
   logic [7:0]  o_class;
   logic        i_flag_clr;
   logic [7:0]  o_flags;
   logic [3:0]  o_count;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   vec_t stream[5];
   vec_t bp[4];

   always #5 clk = ~clk;

   fp_result_pack #(
      .CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_mode     (i_mode),
      .i_sign     (i_sign),
      .i_frac     (i_frac),
      .i_expo     (i_expo),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_mode     (o_mode),
      .o_data     (o_data),
      .o_class    (o_class),
      .i_flag_clr (i_flag_clr),
      .o_flags    (o_flags),
      .o_count    (o_count)
   );

   task automatic check(input string name, input logic [78:0] act, input logic [78:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and wait (bounded) for acceptance; push the expectation
   task automatic send(input vec_t v);
      int   n;
      logic acc;
      exp_t e;
      i_valid = 1'b1;
      i_mode  = v.mode;
      i_sign  = v.sign;
      i_expo  = v.expo;
      i_frac  = v.frac;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         acc = i_ready;
         step();
         n++;
      end
      check("send_accept", 79'(acc), 79'(1));
      if (acc) begin
         e.mode = v.mode;
         e.cls  = v.cls;
         e.data = v.data;
         sb.push_back(e);
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain", 79'(sb.size()), 79'(0));
      step();
   endtask

   function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [15:0] ex,
                               input logic [51:0] fr, input logic [69:0] d, input logic [7:0] c);
      vec_t v;
      v.mode = m;
      v.sign = s;
      v.expo = ex;
      v.frac = fr;
      v.data = d;
      v.cls  = c;
      return v;
   endfunction

   // Monitor: output-order check on transfers, stability check while stalled
   initial begin
      logic        held;
      logic [78:0] held_word;
      logic [78:0] cur;
      exp_t        e;
      held      = 1'b0;
      held_word = '0;
      forever begin
         @(negedge clk);
         cur = {o_mode, o_class, o_data};
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", 79'(o_valid), 79'(1));
               check("hold_stable", cur, held_word);
            end
            if (o_valid && o_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got %h want none", cur);
               end else begin
                  e = sb.pop_front();
                  check("out_word", cur, e);
               end
            end
            held      = o_valid && !o_ready;
            held_word = cur;
         end
      end
   end

   initial begin
      vec_t v1, v2, v3;
      v1 = mk(1'b1, 2'b10, 16'h03FF, 52'h0, 70'h00_BFF0_0000_0000_0000, 8'h00);
      v2 = mk(1'b0, 2'b00, 16'h00FF, {29'h0, 23'h400000},
              {1'b0, 8'h00, 29'h0, 1'b0, 8'hFF, 23'h400000}, 8'h18);
      v3 = mk(1'b1, 2'b00, 16'h07FF, 52'h0, {6'b0, 1'b0, 11'h7FF, 52'h0}, 8'h40);
      stream[0] = mk(1'b1, 2'b11, 16'hF800, 52'h1, {6'b0, 1'b1, 11'h000, 52'h1}, 8'h20);
      stream[1] = mk(1'b1, 2'b00, 16'h07FF, 52'h8_0000_0000_0000,
                     {6'b0, 1'b0, 11'h7FF, 52'h8_0000_0000_0000}, 8'h80);
      stream[2] = mk(1'b0, 2'b01, 16'h00FF, {29'h1, 23'h0},
                     {1'b0, 8'h00, 29'h1, 1'b1, 8'hFF, 23'h0}, 8'h24);
      stream[3] = mk(1'b0, 2'b10, 16'h7F80, {29'h1234567, 23'h2AAAAA},
                     {1'b1, 8'h7F, 29'h1234567, 1'b0, 8'h80, 23'h2AAAAA}, 8'h00);
      stream[4] = mk(1'b0, 2'b11, 16'h0000, 52'h0,
                     {1'b1, 8'h00, 29'h0, 1'b1, 8'h00, 23'h0}, 8'h11);
      for (int k = 0; k < 4; k++) begin
         bp[k] = mk(1'b1, 2'b00, 16'h0400, 52'(k + 10),
                    {6'b0, 1'b0, 11'h400, 52'(k + 10)}, 8'h00);
      end

      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_mode     = 1'b0;
      i_sign     = 2'b00;
      i_frac     = '0;
      i_expo     = '0;
      o_ready    = 1'b0;
      i_flag_clr = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("rst_o_valid", 79'(o_valid), 79'(0));
      check("rst_o_data",  79'(o_data),  79'(0));
      check("rst_o_class", 79'(o_class), 79'(0));
      check("rst_o_mode",  79'(o_mode),  79'(0));
      check("rst_o_flags", 79'(o_flags), 79'(0));
      check("rst_o_count", 79'(o_count), 79'(0));
      check("rst_i_ready", 79'(i_ready), 79'(1));

      // Double-precision word, one cycle latency, then counted
      o_ready = 1'b1;
      send(v1);
      check("v1_latency_valid", 79'(o_valid), 79'(1));
      check("v1_latency_data",  79'(o_data),  79'(70'h00_BFF0_0000_0000_0000));
      step();
      check("v1_count", 79'(o_count), 79'(1));
      check("v1_flags", 79'(o_flags), 79'(0));

      // Packed lanes: lane0 NaN, lane1 zero
      send(v2);
      step();
      check("v2_flags", 79'(o_flags), 79'(8'h18));
      check("v2_count", 79'(o_count), 79'(2));

      // Clear coinciding with an inf transfer
      send(v3);
      i_flag_clr = 1'b1;
      step();
      i_flag_clr = 1'b0;
      check("clr_xfer_flags", 79'(o_flags), 79'(8'h40));
      check("clr_xfer_count", 79'(o_count), 79'(1));

      // Streaming with o_ready high: skid never used
      for (int k = 0; k < 5; k++) begin
         send(stream[k]);
         check("stream_i_ready", 79'(i_ready), 79'(1));
      end
      wait_drain(10);

      // Backpressure: A, B accepted, C waits, words stay in order
      o_ready = 1'b0;
      send(bp[0]);
      send(bp[1]);
      check("bp_i_ready_low", 79'(i_ready), 79'(0));
      check("bp_head_a", 79'(o_data), 79'(bp[0].data));
      i_valid = 1'b1;
      i_mode  = bp[2].mode;
      i_sign  = bp[2].sign;
      i_expo  = bp[2].expo;
      i_frac  = bp[2].frac;
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_stall_i_ready", 79'(i_ready), 79'(0));
         check("bp_stall_a", 79'(o_data), 79'(bp[0].data));
      end
      o_ready = 1'b1;
      send(bp[2]);
      send(bp[3]);
      wait_drain(4);

      // Reset with both entries full discards them
      o_ready = 1'b0;
      send(stream[1]);
      send(stream[2]);
      check("full_i_ready", 79'(i_ready), 79'(0));
      rst_n = 1'b0;
      sb.delete();
      step();
      check("mid_rst_o_valid", 79'(o_valid), 79'(0));
      check("mid_rst_i_ready", 79'(i_ready), 79'(1));
      check("mid_rst_o_flags", 79'(o_flags), 79'(0));
      check("mid_rst_o_count", 79'(o_count), 79'(0));
      rst_n   = 1'b1;
      o_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      check("post_rst_idle", 79'(o_valid), 79'(0));

      // Counter saturation at 4 bits
      for (int k = 0; k < 20; k++) begin
         send(v1);
      end
      wait_drain(10);
      check("count_sat", 79'(o_count), 79'(4'hF));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
